// File: rtl/accel_spi_sequencer.sv
// Brings up an ADXL362-style accelerometer through a byte-level SPI master
// handshake, then periodically burst-reads X/Y/Z and presents 12-bit samples.
`timescale 1ns/1ps
module accel_spi_sequencer #(
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned SAMPLE_PERIOD  = 10000,
  parameter int unsigned CS_IDLE_CYCLES = 8,
  parameter logic [7:0]  DEVID_EXPECT   = 8'hAD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  o_Tx_Byte,
  output logic        o_Tx_Valid,
  input  logic        i_Tx_Ready,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Rx_Ready,
  output logic        o_CSLow,
  output logic [11:0] o_X,
  output logic [11:0] o_Y,
  output logic [11:0] o_Z,
  output logic        o_Sample_Valid,
  output logic        o_Ready,
  output logic        o_Id_Error
);

  localparam int unsigned WAIT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam int unsigned PER_W  = (SAMPLE_PERIOD > 1)  ? $clog2(SAMPLE_PERIOD + 1)  : 1;
  localparam int unsigned IDLE_W = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES + 1) : 1;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;

  typedef enum logic [2:0] {
    WAIT_START, READ_ID, CFG, WAIT_SAMPLE, BURST, ERROR
  } state_t;

  // Per-transaction sub-phase: offer a byte, await its Rx echo, hold CS idle.
  typedef enum logic [1:0] {PH_TX, PH_RX, PH_IDLE} phase_t;

  state_t            r_state;
  phase_t            r_phase;
  logic [2:0]        r_idx;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [PER_W-1:0]  r_period_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [7:0]        r_xl;
  logic [3:0]        r_xh;
  logic [7:0]        r_yl;
  logic [3:0]        r_yh;
  logic [7:0]        r_zl;

  logic [7:0]        w_tx_byte;
  logic              w_last;
  logic              w_period_tick;

  assign w_period_tick = o_Ready && (r_period_cnt == PER_W'(SAMPLE_PERIOD - 1));

  // Byte to send and end-of-transaction flag for the current command.
  always_comb begin
    w_tx_byte = 8'h00;
    w_last    = 1'b0;
    case (r_state)
      READ_ID: begin
        w_tx_byte = (r_idx == 3'd0) ? CMD_READ : 8'h00;
        w_last    = (r_idx == 3'd2);
      end
      CFG: begin
        case (r_idx)
          3'd0:    w_tx_byte = CMD_WRITE;
          3'd1:    w_tx_byte = REG_POWER_CTL;
          default: w_tx_byte = PWR_MEASURE;
        endcase
        w_last = (r_idx == 3'd2);
      end
      BURST: begin
        case (r_idx)
          3'd0:    w_tx_byte = CMD_READ;
          3'd1:    w_tx_byte = REG_XDATA_L;
          default: w_tx_byte = 8'h00;
        endcase
        w_last = (r_idx == 3'd7);
      end
      default: ;
    endcase
  end

  // Sequencer FSM; starting a transaction drops CS one cycle ahead of the first byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= WAIT_START;
      r_phase        <= PH_TX;
      r_idx          <= '0;
      r_wait_cnt     <= '0;
      r_period_cnt   <= '0;
      r_idle_cnt     <= '0;
      r_xl           <= '0;
      r_xh           <= '0;
      r_yl           <= '0;
      r_yh           <= '0;
      r_zl           <= '0;
      o_Tx_Byte      <= '0;
      o_Tx_Valid     <= 1'b0;
      o_CSLow        <= 1'b1;
      o_X            <= '0;
      o_Y            <= '0;
      o_Z            <= '0;
      o_Sample_Valid <= 1'b0;
      o_Ready        <= 1'b0;
      o_Id_Error     <= 1'b0;
    end else begin
      o_Sample_Valid <= 1'b0;
      // Free-running sample period; a tick that lands mid-burst is simply lost.
      if (o_Ready) begin
        r_period_cnt <= w_period_tick ? '0 : r_period_cnt + PER_W'(1);
      end
      case (r_state)
        WAIT_START: begin
          if (r_wait_cnt == WAIT_W'(STARTUP_CYCLES - 1)) begin
            r_state <= READ_ID;
            r_phase <= PH_TX;
            r_idx   <= '0;
            o_CSLow <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        WAIT_SAMPLE: begin
          if (w_period_tick) begin
            r_state <= BURST;
            r_phase <= PH_TX;
            r_idx   <= '0;
            o_CSLow <= 1'b0;
          end
        end
        READ_ID, CFG, BURST: begin
          case (r_phase)
            PH_TX: begin
              if (!o_Tx_Valid) begin
                o_Tx_Valid <= 1'b1;
                o_Tx_Byte  <= w_tx_byte;
              end else if (i_Tx_Ready) begin
                o_Tx_Valid <= 1'b0;
                r_phase    <= PH_RX;
              end
            end
            PH_RX: begin
              if (i_Rx_Ready) begin
                r_idx <= r_idx + 3'd1;
                if (r_state == BURST) begin
                  case (r_idx)
                    3'd2:    r_xl <= i_Rx_Byte;
                    3'd3:    r_xh <= i_Rx_Byte[3:0];
                    3'd4:    r_yl <= i_Rx_Byte;
                    3'd5:    r_yh <= i_Rx_Byte[3:0];
                    3'd6:    r_zl <= i_Rx_Byte;
                    default: ;
                  endcase
                end
                if (w_last) begin
                  o_CSLow    <= 1'b1;
                  r_phase    <= PH_IDLE;
                  r_idle_cnt <= '0;
                  if (r_state == READ_ID && i_Rx_Byte != DEVID_EXPECT) begin
                    o_Id_Error <= 1'b1;
                    r_state    <= ERROR;
                  end
                  if (r_state == BURST) begin
                    o_X            <= {r_xh, r_xl};
                    o_Y            <= {r_yh, r_yl};
                    o_Z            <= {i_Rx_Byte[3:0], r_zl};
                    o_Sample_Valid <= 1'b1;
                    r_state        <= WAIT_SAMPLE;
                  end
                end else begin
                  r_phase <= PH_TX;
                end
              end
            end
            default: begin
              // CS is high here; configuration done, or idle gap before CFG.
              if (r_state == CFG) begin
                o_Ready      <= 1'b1;
                r_period_cnt <= '0;
                r_state      <= WAIT_SAMPLE;
              end else if (r_idle_cnt == IDLE_W'(CS_IDLE_CYCLES - 1)) begin
                r_state <= CFG;
                r_phase <= PH_TX;
                r_idx   <= '0;
                o_CSLow <= 1'b0;
              end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
              end
            end
          endcase
        end
        default: begin
          o_CSLow    <= 1'b1;
          o_Tx_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Bench for accel_spi_sequencer: behavioural SPI master + ADXL362 register
// model, with MOSI bytes and decoded samples checked against queued expectations.
`timescale 1ns/1ps
module tb_accel_spi_sequencer;

  localparam int unsigned PERIOD = 2000;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
  } sample_t;

  logic        clk;
  logic        reset;
  logic [7:0]  o_Tx_Byte;
  logic        o_Tx_Valid;
  logic        i_Tx_Ready;
  logic [7:0]  i_Rx_Byte;
  logic        i_Rx_Ready;
  logic        o_CSLow;
  logic [11:0] o_X;
  logic [11:0] o_Y;
  logic [11:0] o_Z;
  logic        o_Sample_Valid;
  logic        o_Ready;
  logic        o_Id_Error;

  accel_spi_sequencer #(
    .STARTUP_CYCLES(50),
    .SAMPLE_PERIOD (PERIOD),
    .CS_IDLE_CYCLES(8),
    .DEVID_EXPECT  (8'hAD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .o_Tx_Byte     (o_Tx_Byte),
    .o_Tx_Valid    (o_Tx_Valid),
    .i_Tx_Ready    (i_Tx_Ready),
    .i_Rx_Byte     (i_Rx_Byte),
    .i_Rx_Ready    (i_Rx_Ready),
    .o_CSLow       (o_CSLow),
    .o_X           (o_X),
    .o_Y           (o_Y),
    .o_Z           (o_Z),
    .o_Sample_Valid(o_Sample_Valid),
    .o_Ready       (o_Ready),
    .o_Id_Error    (o_Id_Error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] exp_mosi[$];
  sample_t    exp_samples[$];
  logic [7:0] regs[0:63];

  int     n_checks;
  int     n_errors;
  longint cycle;
  longint sv_time[0:63];
  int     sv_cnt;
  int     cs_falls;
  int     mosi_cnt;
  int     rx_pos;
  bit     bp_arm;
  bit     bp_done;

  // bfm-private state
  int         pos_tx;
  int         rx_cd;
  int         stall;
  logic [7:0] cmd;
  logic [7:0] addr;
  logic [7:0] miso;
  logic [7:0] e_byte;
  sample_t    e_smp;
  logic       acc;
  logic       prev_valid;
  logic       prev_acc;
  logic       prev_cs;
  logic       prev_sv;
  logic [7:0] prev_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_bringup_mosi();
    exp_mosi.push_back(8'h0B); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
    exp_mosi.push_back(8'h0A); exp_mosi.push_back(8'h2D); exp_mosi.push_back(8'h02);
  endfunction

  function automatic void push_burst_mosi();
    exp_mosi.push_back(8'h0B);
    exp_mosi.push_back(8'h0E);
    for (int i = 0; i < 6; i++) exp_mosi.push_back(8'h00);
  endfunction

  // Load sample registers (random junk in the unused high nibbles) and expect the sample.
  function automatic void load_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    logic [11:0] junk;
    junk = 12'($urandom);
    regs[14] = x[7:0]; regs[15] = {junk[3:0],  x[11:8]};
    regs[16] = y[7:0]; regs[17] = {junk[7:4],  y[11:8]};
    regs[18] = z[7:0]; regs[19] = {junk[11:8], z[11:8]};
    exp_samples.push_back({x, y, z});
  endfunction

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!o_Ready && n < budget) begin @(negedge clk); n++; end
    chk("ready_rise", 32'(o_Ready), 32'd1);
  endtask

  task automatic wait_sv(input int target, input int budget);
    int n;
    n = 0;
    while (sv_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk("sample_wait", 32'(sv_cnt), 32'(target));
  endtask

  // Behavioural SPI master + slave and output monitor, all on the falling edge.
  initial begin : bfm
    pos_tx = 0; rx_cd = 0; stall = 0; cmd = '0; addr = '0; miso = '0;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_cs = 1'b1; prev_sv = 1'b0; prev_byte = '0;
    i_Tx_Ready = 1'b1; i_Rx_Ready = 1'b0; i_Rx_Byte = '0;
    forever begin
      @(negedge clk);
      cycle++;
      i_Rx_Ready = 1'b0;
      if (!reset) mosi_cnt = 0;
      if (!reset || o_CSLow) begin
        pos_tx = 0; rx_pos = 0; rx_cd = 0;
      end
      if (rx_cd > 0) begin
        rx_cd--;
        if (rx_cd == 0) begin
          i_Rx_Ready = 1'b1;
          i_Rx_Byte  = miso;
          rx_pos++;
        end
      end
      if (stall > 0) stall--;
      else if (bp_arm && !bp_done && o_Tx_Valid && !o_CSLow && pos_tx == 4) begin
        stall   = 50;
        bp_done = 1'b1;
      end
      i_Tx_Ready = (stall == 0);

      acc = reset && o_Tx_Valid && i_Tx_Ready;
      if (acc) begin
        chk("cs_at_tx", 32'(o_CSLow), 32'd0);
        if (exp_mosi.size() == 0) chk("mosi_extra", 32'(o_Tx_Byte) + 32'h100, 32'h0);
        else begin
          e_byte = exp_mosi.pop_front();
          chk("mosi", 32'(o_Tx_Byte), 32'(e_byte));
        end
        case (pos_tx)
          0: cmd = o_Tx_Byte;
          1: addr = o_Tx_Byte;
          default: if (cmd == 8'h0A) regs[6'(int'(addr) + pos_tx - 2)] = o_Tx_Byte;
        endcase
        if (pos_tx < 2)          miso = 8'hFF;
        else if (cmd == 8'h0B)   miso = regs[6'(int'(addr) + pos_tx - 2)];
        else                     miso = 8'h00;
        pos_tx++;
        mosi_cnt++;
        rx_cd = 4;
      end

      if (reset && prev_valid && !prev_acc)
        chk("tx_hold", {23'd0, o_Tx_Valid, o_Tx_Byte}, {23'd0, 1'b1, prev_byte});
      if (reset && o_Tx_Valid && !prev_valid)
        chk("cs_setup", 32'(prev_cs), 32'd0);
      if (reset && prev_cs && !o_CSLow) cs_falls++;

      if (o_Sample_Valid) begin
        chk("sv_width", 32'(prev_sv), 32'd0);
        if (exp_samples.size() == 0) chk("sample_extra", 32'd1, 32'd0);
        else begin
          e_smp = exp_samples.pop_front();
          chk("x", 32'(o_X), 32'(e_smp.x));
          chk("y", 32'(o_Y), 32'(e_smp.y));
          chk("z", 32'(o_Z), 32'(e_smp.z));
        end
        if (sv_cnt < 64) sv_time[sv_cnt] = cycle;
        sv_cnt++;
      end

      prev_valid = o_Tx_Valid && reset;
      prev_acc   = acc;
      prev_cs    = o_CSLow;
      prev_sv    = o_Sample_Valid;
      prev_byte  = o_Tx_Byte;
    end
  end

  initial begin : main
    int n;
    int base;
    n_checks = 0; n_errors = 0; cycle = 0; sv_cnt = 0; cs_falls = 0;
    mosi_cnt = 0; rx_pos = 0; bp_arm = 1'b0; bp_done = 1'b0;
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;
    regs[0]  = 8'hAD;
    regs[14] = 8'h34; regs[15] = 8'hF2; regs[16] = 8'hFF;
    regs[17] = 8'h0F; regs[18] = 8'h00; regs[19] = 8'h08;
    push_bringup_mosi();
    push_burst_mosi();
    exp_samples.push_back({12'h234, 12'hFFF, 12'h800});

    // Reset state
    reset = 1'b0;
    #7;
    chk("rst_cs",    32'(o_CSLow),    32'd1);
    chk("rst_valid", 32'(o_Tx_Valid), 32'd0);
    chk("rst_byte",  32'(o_Tx_Byte),  32'd0);
    chk("rst_xyz",   {o_X, o_Y, o_Z} == 36'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("rst_flags", {29'd0, o_Sample_Valid, o_Ready, o_Id_Error}, 32'd0);
    #13 reset = 1'b1;

    // Bring-up: ID read then POWER_CTL write; ready follows the CFG CS release
    wait_ready(2000);
    chk("ready_mosi_cnt", 32'(mosi_cnt), 32'd6);
    chk("ready_cs_high",  32'(o_CSLow), 32'd1);
    chk("ready_id_err",   32'(o_Id_Error), 32'd0);
    chk("powerctl_reg",   32'(regs[45]), 32'h02);

    // Burst decode of the reference pattern
    wait_sv(1, 3 * PERIOD);

    // Periodicity across five samples with varied data, including sign boundaries
    load_sample(12'h7FF, 12'h000, 12'h001); push_burst_mosi(); wait_sv(2, 3 * PERIOD);
    load_sample(12'h800, 12'h7FF, 12'hFFE); push_burst_mosi(); wait_sv(3, 3 * PERIOD);
    load_sample(12'($urandom), 12'($urandom), 12'($urandom)); push_burst_mosi(); wait_sv(4, 3 * PERIOD);
    load_sample(12'($urandom), 12'($urandom), 12'($urandom)); push_burst_mosi(); wait_sv(5, 3 * PERIOD);
    for (int k = 1; k < 5; k++)
      chk("period", 32'(sv_time[k] - sv_time[k-1]), 32'(PERIOD));

    // Backpressure: i_Tx_Ready held low 50 cycles in the middle of a burst
    bp_arm = 1'b1;
    load_sample(12'h5A5, 12'h0F0, 12'hA5A); push_burst_mosi();
    wait_sv(6, 3 * PERIOD);
    chk("bp_hit", 32'(bp_done), 32'd1);
    chk("bp_mosi_left", 32'(exp_mosi.size()), 32'd0);

    // Reset in the middle of a burst after its 4th byte
    push_burst_mosi();
    n = 0;
    while (rx_pos < 4 && n < 3 * PERIOD) begin @(negedge clk); n++; end
    chk("abort_reach", 32'(rx_pos >= 4), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_cs",    32'(o_CSLow), 32'd1);
    chk("abort_valid", 32'(o_Tx_Valid), 32'd0);
    chk("abort_ready", 32'(o_Ready), 32'd0);
    chk("abort_sv",    32'(o_Sample_Valid), 32'd0);
    exp_mosi.delete();
    #16;
    push_bringup_mosi();
    load_sample(12'h123, 12'hEDC, 12'h0A0); push_burst_mosi();
    reset = 1'b1;
    wait_ready(2000);
    chk("rebringup_cnt", 32'(mosi_cnt), 32'd6);
    chk("abort_no_sample", 32'(sv_cnt), 32'd6);
    wait_sv(7, 3 * PERIOD);

    // Device ID mismatch: sticky error, no ready, CS stays quiet
    @(negedge clk);
    #2 reset = 1'b0;
    exp_mosi.delete();
    exp_samples.delete();
    regs[0] = 8'h00;
    exp_mosi.push_back(8'h0B); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
    #20 reset = 1'b1;
    n = 0;
    while (!o_Id_Error && n < 2000) begin @(negedge clk); n++; end
    chk("id_err_set",   32'(o_Id_Error), 32'd1);
    chk("id_err_ready", 32'(o_Ready), 32'd0);
    base = cs_falls;
    repeat (10 * PERIOD) @(negedge clk);
    chk("id_err_quiet",  32'(cs_falls - base), 32'd0);
    chk("id_err_sticky", 32'(o_Id_Error), 32'd1);
    chk("id_err_noready", 32'(o_Ready), 32'd0);
    chk("id_err_cs",     32'(o_CSLow), 32'd1);
    chk("id_mosi_left",  32'(exp_mosi.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accel_spi_sequencer.md
Name: accel_spi_sequencer

Overview:
Command sequencer that sits directly upstream of SPIMaster in the accelerometer driver. It brings up an ADXL362-style accelerometer: checks the device ID, then writes POWER_CTL to enable measurement. It then periodically burst-reads the X/Y/Z sample registers. All traffic goes through SPIMaster's byte handshake. The block owns chip-select so that multi-byte transactions are not split, and it presents assembled 12-bit samples to downstream logic.

Parameters:
STARTUP_CYCLES, 1000, clk cycles to wait after reset before the first transaction (minimum 1)
SAMPLE_PERIOD, 10000, clk cycles between starts of consecutive sample bursts (must exceed one burst length)
CS_IDLE_CYCLES, 8, clk cycles o_CSLow is held high between transactions
DEVID_EXPECT, 8'hAD, expected value of register 0x00

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
o_Tx_Byte  out  8  byte to SPIMaster
o_Tx_Valid  out  1  o_Tx_Byte valid
i_Tx_Ready  in  1  SPIMaster can accept a byte
i_Rx_Byte  in  8  byte received by SPIMaster
i_Rx_Ready  in  1  one-cycle pulse, i_Rx_Byte valid
o_CSLow  out  1  accelerometer chip select (active-low); SPIMaster's CS is not used
o_X, o_Y, o_Z  out  12 each  latest sample, two's complement
o_Sample_Valid  out  1  one-cycle pulse when o_X/o_Y/o_Z update
o_Ready  out  1  high once configuration has completed
o_Id_Error  out  1  sticky flag: device ID mismatch

Behaviour:
- Reset values (asserted asynchronously on reset=0): o_Tx_Byte=0, o_Tx_Valid=0, o_CSLow=1, o_X/o_Y/o_Z=0, o_Sample_Valid=0, o_Ready=0, o_Id_Error=0, state=WAIT_START, all counters=0.
- Byte handshake: a byte is accepted in the cycle where o_Tx_Valid && i_Tx_Ready. o_Tx_Byte is held stable while o_Tx_Valid=1. o_Tx_Valid drops the cycle after acceptance.
- Pacing: the next byte is not offered until the i_Rx_Ready pulse for the previous byte has been seen. Exactly one Rx byte is counted per Tx byte.
- Chip select: o_CSLow goes to 0 at least one cycle before the first o_Tx_Valid of a transaction. It returns to 1 the cycle after the final i_Rx_Ready of that transaction, then stays high for CS_IDLE_CYCLES.
- The Rx bytes for the command and address phases are discarded. Only the data-phase bytes are used.
- States:
  - WAIT_START: count STARTUP_CYCLES, then go to READ_ID.
  - READ_ID: send 0x0B, 0x00, 0x00. Compare the third Rx byte against DEVID_EXPECT.
    - Mismatch: set o_Id_Error=1 and go to ERROR.
    - Match: go to CFG.
  - CFG: send 0x0A, 0x2D, 0x02. After CS goes high, set o_Ready=1 and go to WAIT_SAMPLE.
  - WAIT_SAMPLE: the period counter runs from the cycle o_Ready rises. When it reaches SAMPLE_PERIOD-1, go to BURST and reload the counter.
  - BURST: send 0x0B, 0x0E, then 6 dummy bytes of 0x00. Data bytes are XL, XH, YL, YH, ZL, ZH.
    - Sample assembly: o_X = {XH[3:0], XL}, and likewise for Y and Z.
    - All three outputs update in the same cycle, together with o_Sample_Valid=1 for exactly one cycle. This happens on the cycle after the 8th i_Rx_Ready.
    - Then go to WAIT_SAMPLE.
  - ERROR: terminal state. o_CSLow=1, o_Tx_Valid=0. Leaving ERROR requires reset.
- The period counter keeps running during BURST. If the period expires while a burst is still in progress, that tick is dropped, not queued.
- An i_Rx_Ready arriving with no byte outstanding is ignored.
- Reset mid-transaction: all outputs return to their reset values immediately, including o_CSLow=1. The sequence restarts from WAIT_START.
- o_X/o_Y/o_Z hold their values between bursts.

Test Plan:
- Bring-up: reset low 20 ns; behavioural slave returns 0xAD at reg 0x00 → the MOSI byte stream is 0B 00 00, then 0A 2D 02; o_Ready rises after the CFG CS deassertion; o_Id_Error=0.
- ID mismatch: slave returns 0x00 at reg 0x00 → o_Id_Error=1, o_Ready stays 0, and no further CS activity for 10×SAMPLE_PERIOD.
- Burst decode: slave data regs 0x0E..0x13 = 34 F2 FF 0F 00 08 → o_X=0x234, o_Y=0xFFF, o_Z=0x800 with a single o_Sample_Valid pulse; CS stays low across all 8 bytes.
- Periodicity: SAMPLE_PERIOD=2000 → consecutive o_Sample_Valid pulses are exactly 2000 cycles apart over 5 samples.
- Backpressure: hold i_Tx_Ready=0 for 50 cycles mid-burst → o_Tx_Valid and o_Tx_Byte stay stable; no byte is lost or duplicated; the decoded sample is still correct.
- Reset during BURST, after the 4th byte → o_CSLow=1 asynchronously, o_Sample_Valid never pulses for the aborted burst, and the full bring-up sequence repeats.
